pigasus_match_serializer: RTL and testbench
===========================================

// Module: pigasus_match_serializer
// PURPOSE
//  Parametrised successor to the SME match-output stage: accepts per-beat LANES x RULE_W rule-ID vectors
//  from port_group (0 = no match), buffers them, and serialises them into a valid/ready stream of single
//  rule IDs with packet-end marking. Replaces the mask/release scheme: adds backpressure, per-beat dedup,
//  an empty-packet terminator, overflow accounting and statistics. Sits between port_group and the core's
//  match interface.
// PARAMETERS
//  LANES       8   rule-ID slots per input beat
//  RULE_W      16  rule-ID width; ID 0 is reserved (= no match)
//  FIFO_DEPTH  4   input beat buffer depth; power of 2, >=2
//  DEDUP       1   1: drop repeated IDs within one beat; 0: emit every non-zero lane
//  CNT_W       32  statistics counter width
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              asynchronous active-low reset
//  clear         in   1              sync flush of all buffered/in-flight matches (new packet / reload)
//  s_rules       in   LANES*RULE_W   lane k = s_rules[k*RULE_W +: RULE_W]
//  s_last        in   1              beat is the last of its packet
//  s_valid       in   1              input beat valid
//  s_ready       out  1              FIFO not full
//  m_rule_id     out  RULE_W         matched rule ID (0 only on empty-packet terminator)
//  m_last        out  1              last match of packet
//  m_valid       out  1              output valid
//  m_ready       in   1              output accepted
//  stat_matches  out  CNT_W          rule IDs emitted (m_valid&m_ready, rule_id!=0)
//  stat_drops    out  CNT_W          beats lost: s_valid & ~s_ready
//  lane_hits     out  LANES          sticky OR of non-zero lanes since last clear
// BEHAVIOUR
//  - Reset (rst_n=0, async): FIFO empty, head empty, m_valid=0, m_rule_id=0, m_last=0, s_ready=1 on
//    release, counters=0, lane_hits=0.
//  - Input: beat accepted when s_valid&s_ready. Beats with all lanes 0 and s_last=0 are counted as
//    accepted but not written. Otherwise {s_last, s_rules} is written. s_valid while full: beat
//    discarded, stat_drops+1 (upstream may ignore s_ready).
//  - Dedup (DEDUP=1): applied on write; lane k zeroed if equal to any lane j<k. No cross-beat dedup.
//  - Head stage: holds one beat plus a LANES-bit pending mask (lanes != 0). States:
//    EMPTY -> LOAD when FIFO non-empty; LOAD -> EMIT (mask!=0) or TERM (mask==0, last=1).
//    EMIT emits the lowest pending lane and clears its bit.
//    TERM emits rule_id=0, m_last=1 once.
//    After the final emission the next FIFO beat loads in the same cycle: no bubble.
//  - Output regs hold while m_valid & ~m_ready; m_rule_id/m_last must not change until accepted.
//  - m_last=1 on the final pending lane of a beat with last=1; otherwise 0.
//  - Throughput: one ID per cycle sustained with m_ready=1.
//  - Latency: beat accepted at edge E with the path empty -> m_valid=1 after edge E+2.
//  - clear (sync, priority over all else except reset): FIFO, head, and output regs emptied; m_valid=0
//    next cycle; lane_hits=0; a beat offered in the clear cycle is discarded, not counted as drop.
//    Counters not cleared.
//  - Counters saturate at all-ones, never wrap.
//  - Simultaneous FIFO write and read when full: read frees slot, but s_ready is from registered full
//    flag, so the write is refused that cycle.
// STRUCTURE
//  - Package pigasus_match_pkg: rule_id_t (logic [RULE_W-1:0]), beat_t struct {last, rules[LANES]},
//    head-state enum {H_EMPTY,H_LOAD,H_EMIT,H_TERM}, NO_MATCH='0.
//  - Sub-module match_fifo: sync FIFO, async active-low reset, sync clear; ports
//    din/din_valid/din_ready, dout/dout_valid/dout_ready, full, empty.
//  - Dedup compare network and lowest-set priority encoder stay in this module.
// TESTING
//  1. Beat lanes {0x0005,0,0x0009,0...}, last=1, m_ready=1 -> 0x0005 (last=0), then 0x0009 (last=1);
//     first m_valid 2 cycles after accept.
//  2. DEDUP=1, lanes {7,7,3,7,0...}, last=1 -> exactly 7, 3 (last on 3); DEDUP=0 -> 7,7,3,7.
//  3. Zero beat last=0, then zero beat last=1 -> single output rule_id=0, m_last=1; stat_matches unchanged.
//  4. m_ready=0 for 10 cycles with 6 beats pushed (FIFO_DEPTH=4) -> s_ready low after 5 accepts (4+head),
//     stat_drops=1, output stable throughout; then m_ready=1 drains all in order.
//  5. clear asserted mid-emission of an 8-match beat -> m_valid=0 next cycle, no stale IDs afterwards,
//     lane_hits=0, counters retained.
//  6. rst_n pulsed low asynchronously mid-packet -> all outputs 0 immediately; CNT_W=4 saturation at 0xF.

Source files
------------

// File: rtl/pigasus_match_serializer_pkg.sv
// Shared types and defaults for the Pigasus match serializer.
// Head-stage states and the reserved no-match rule ID live here.
package pigasus_match_pkg;

    localparam int DEF_LANES      = 8;
    localparam int DEF_RULE_W     = 16;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_DEDUP      = 1;
    localparam int DEF_CNT_W      = 32;

    typedef logic [DEF_RULE_W-1:0] rule_id_t;

    typedef struct packed {
        logic                       last;
        rule_id_t [DEF_LANES-1:0]   rules;
    } beat_t;

    typedef enum logic [1:0] {
        H_EMPTY,
        H_LOAD,
        H_EMIT,
        H_TERM
    } head_state_t;

    localparam rule_id_t NO_MATCH = '0;

endpackage

// File: rtl/pigasus_match_serializer_fifo.sv
// Synchronous beat FIFO with async reset and sync flush.
// Full/empty come straight from the registered occupancy count.
module match_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [AW:0]      cnt;
    logic             wr;
    logic             rd;

    assign full       = (cnt == (AW+1)'(DEPTH));
    assign empty      = (cnt == '0);
    assign din_ready  = ~full;
    assign dout_valid = ~empty;
    assign dout       = mem[rp];
    assign wr         = din_valid & ~full;
    assign rd         = dout_ready & ~empty;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else if (clear) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (wr) begin
                wp <= wp + 1'b1;
            end
            if (rd) begin
                rp <= rp + 1'b1;
            end
            case ({wr, rd})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/pigasus_match_serializer.sv
// Buffers per-beat rule-ID vectors and serialises them into a
// valid/ready stream of single IDs with packet-end marking.
module pigasus_match_serializer
    import pigasus_match_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int RULE_W     = DEF_RULE_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DEDUP      = DEF_DEDUP,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic [LANES*RULE_W-1:0] s_rules,
    input  logic                    s_last,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic [RULE_W-1:0]       m_rule_id,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [CNT_W-1:0]        stat_matches,
    output logic [CNT_W-1:0]        stat_drops,
    output logic [LANES-1:0]        lane_hits
);

    localparam int BW = LANES * RULE_W;
    localparam int FW = BW + 1;

    logic [LANES-1:0] in_nz;
    logic [BW-1:0]    dd_rules;
    logic             accept;
    logic             wr_en;

    logic             fifo_din_ready;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_dout_valid;
    logic             fifo_pop;
    logic             fifo_avail;
    logic [FW-1:0]    fifo_dout;

    head_state_t      hstate;
    logic [BW-1:0]    hrules;
    logic             hlast;
    logic [LANES-1:0] hmask;
    logic [LANES-1:0] lsb;
    logic [LANES-1:0] mask_nxt;
    logic [LANES-1:0] dout_nz;
    logic [RULE_W-1:0] sel_rule;
    logic             hbusy;
    logic             out_free;
    logic             fire;
    logic             last_em;

    always_comb begin
        in_nz = '0;
        for (int k = 0; k < LANES; k++) begin
            in_nz[k] = |s_rules[k*RULE_W +: RULE_W];
        end
    end

    // A lane repeating any earlier lane of the same beat is dropped.
    always_comb begin
        dd_rules = s_rules;
        if (DEDUP != 0) begin
            for (int k = 1; k < LANES; k++) begin
                for (int j = 0; j < k; j++) begin
                    if (s_rules[k*RULE_W +: RULE_W] == s_rules[j*RULE_W +: RULE_W]) begin
                        dd_rules[k*RULE_W +: RULE_W] = '0;
                    end
                end
            end
        end
    end

    assign s_ready = ~fifo_full;
    assign accept  = s_valid & s_ready & ~clear;
    assign wr_en   = accept & fifo_din_ready & ((|in_nz) | s_last);

    match_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .din        ({s_last, dd_rules}),
        .din_valid  (wr_en),
        .din_ready  (fifo_din_ready),
        .dout       (fifo_dout),
        .dout_valid (fifo_dout_valid),
        .dout_ready (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    always_comb begin
        lsb      = hmask & (~hmask + 1'b1);
        mask_nxt = hmask & ~lsb;
        sel_rule = '0;
        dout_nz  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (lsb[k]) begin
                sel_rule = hrules[k*RULE_W +: RULE_W];
            end
            dout_nz[k] = |fifo_dout[k*RULE_W +: RULE_W];
        end
    end

    assign hbusy      = (hstate != H_EMPTY);
    assign out_free   = ~m_valid | m_ready;
    assign fire       = hbusy & out_free;
    assign last_em    = (mask_nxt == '0);
    assign fifo_avail = fifo_dout_valid & ~fifo_empty;
    // Refill on the final emission so back-to-back beats leave no bubble.
    assign fifo_pop   = fifo_avail & (~hbusy | (fire & last_em));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hstate    <= H_EMPTY;
            hrules    <= '0;
            hlast     <= 1'b0;
            hmask     <= '0;
            m_valid   <= 1'b0;
            m_rule_id <= RULE_W'(NO_MATCH);
            m_last    <= 1'b0;
        end else if (clear) begin
            hstate    <= H_EMPTY;
            hrules    <= '0;
            hlast     <= 1'b0;
            hmask     <= '0;
            m_valid   <= 1'b0;
            m_rule_id <= RULE_W'(NO_MATCH);
            m_last    <= 1'b0;
        end else begin
            if (fire) begin
                m_valid   <= 1'b1;
                m_rule_id <= sel_rule;
                m_last    <= hlast & last_em;
            end else if (m_ready) begin
                m_valid   <= 1'b0;
            end
            if (fifo_pop) begin
                hstate <= H_LOAD;
                hrules <= fifo_dout[BW-1:0];
                hlast  <= fifo_dout[BW];
                hmask  <= dout_nz;
            end else if (fire) begin
                hstate <= last_em ? H_EMPTY : H_EMIT;
                hmask  <= mask_nxt;
            end else if (hstate == H_LOAD) begin
                hstate <= (|hmask) ? H_EMIT : H_TERM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_matches <= '0;
            stat_drops   <= '0;
            lane_hits    <= '0;
        end else begin
            if (m_valid & m_ready & (|m_rule_id) & ~(&stat_matches)) begin
                stat_matches <= stat_matches + 1'b1;
            end
            if (s_valid & ~s_ready & ~clear & ~(&stat_drops)) begin
                stat_drops <= stat_drops + 1'b1;
            end
            if (clear) begin
                lane_hits <= '0;
            end else if (accept) begin
                lane_hits <= lane_hits | in_nz;
            end
        end
    end

endmodule

// File: tb/tb_pigasus_match_serializer.sv
// Directed bench: default, no-dedup and 4-bit-counter instances share stimulus.
module tb_pigasus_match_serializer;

    localparam int LANES = 8;
    localparam int RW    = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic [LANES*RW-1:0] s_rules = '0;
    logic               s_last = 1'b0;
    logic               s_valid = 1'b0;
    logic               m_ready = 1'b0;

    logic               a_s_ready, a_m_last, a_m_valid;
    logic [RW-1:0]      a_m_rule_id;
    logic [31:0]        a_stat_matches, a_stat_drops;
    logic [LANES-1:0]   a_lane_hits;

    logic               b_s_ready, b_m_last, b_m_valid;
    logic [RW-1:0]      b_m_rule_id;
    logic [31:0]        b_stat_matches, b_stat_drops;
    logic [LANES-1:0]   b_lane_hits;

    logic               c_s_ready, c_m_last, c_m_valid;
    logic [RW-1:0]      c_m_rule_id;
    logic [3:0]         c_stat_matches, c_stat_drops;
    logic [LANES-1:0]   c_lane_hits;

    int                 n_cmp = 0;
    int                 n_err = 0;
    logic [31:0]        qa[$];
    logic [31:0]        qb[$];

    pigasus_match_serializer dut (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .s_rules (s_rules), .s_last (s_last), .s_valid (s_valid), .s_ready (a_s_ready),
        .m_rule_id (a_m_rule_id), .m_last (a_m_last), .m_valid (a_m_valid), .m_ready (m_ready),
        .stat_matches (a_stat_matches), .stat_drops (a_stat_drops), .lane_hits (a_lane_hits)
    );

    pigasus_match_serializer #(.DEDUP(0)) dut_nd (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .s_rules (s_rules), .s_last (s_last), .s_valid (s_valid), .s_ready (b_s_ready),
        .m_rule_id (b_m_rule_id), .m_last (b_m_last), .m_valid (b_m_valid), .m_ready (m_ready),
        .stat_matches (b_stat_matches), .stat_drops (b_stat_drops), .lane_hits (b_lane_hits)
    );

    pigasus_match_serializer #(.CNT_W(4)) dut_c4 (
        .clk (clk), .rst_n (rst_n), .clear (clear),
        .s_rules (s_rules), .s_last (s_last), .s_valid (s_valid), .s_ready (c_s_ready),
        .m_rule_id (c_m_rule_id), .m_last (c_m_last), .m_valid (c_m_valid), .m_ready (m_ready),
        .stat_matches (c_stat_matches), .stat_drops (c_stat_drops), .lane_hits (c_lane_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*RW-1:0] pk(
        input logic [15:0] l0, input logic [15:0] l1, input logic [15:0] l2, input logic [15:0] l3,
        input logic [15:0] l4, input logic [15:0] l5, input logic [15:0] l6, input logic [15:0] l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    task automatic collect(input int n);
        qa.delete();
        qb.delete();
        repeat (n) begin
            if (a_m_valid && m_ready) qa.push_back({15'd0, a_m_last, a_m_rule_id});
            if (b_m_valid && m_ready) qb.push_back({15'd0, b_m_last, b_m_rule_id});
            step();
        end
    endtask

    task automatic push(input logic [LANES*RW-1:0] r, input logic last);
        s_rules = r;
        s_last  = last;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        s_rules = '0;
        s_last  = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_out", {a_m_valid, a_m_last, a_m_rule_id}, 32'h0);
        chk("rst_s_ready", a_s_ready, 32'h1);
        chk("rst_stats", {a_stat_matches[7:0], a_stat_drops[7:0], a_lane_hits}, 32'h0);
        rst_n = 1'b1;
        step();
        chk("rel_s_ready", a_s_ready, 32'h1);

        // 1: basic two-lane beat and latency
        m_ready = 1'b1;
        push(pk(16'h5, 0, 16'h9, 0, 0, 0, 0, 0), 1'b1);
        chk("t1_lat_e1", a_m_valid, 32'h0);
        step();
        chk("t1_lat_e2", a_m_valid, 32'h0);
        step();
        chk("t1_first", {a_m_valid, a_m_last, a_m_rule_id}, 32'h20005);
        step();
        chk("t1_second", {a_m_valid, a_m_last, a_m_rule_id}, 32'h30009);
        step();
        chk("t1_idle", a_m_valid, 32'h0);
        chk("t1_matches", a_stat_matches, 32'd2);
        chk("t1_lane_hits", a_lane_hits, 32'h05);

        // 2: dedup on / off
        push(pk(16'h7, 16'h7, 16'h3, 16'h7, 0, 0, 0, 0), 1'b1);
        collect(10);
        chk("t2_dd_cnt", qa.size(), 32'd2);
        if (qa.size() == 2) begin
            chk("t2_dd_0", qa[0], 32'h00007);
            chk("t2_dd_1", qa[1], 32'h10003);
        end
        chk("t2_nd_cnt", qb.size(), 32'd4);
        if (qb.size() == 4) begin
            chk("t2_nd_0", qb[0], 32'h00007);
            chk("t2_nd_1", qb[1], 32'h00007);
            chk("t2_nd_2", qb[2], 32'h00003);
            chk("t2_nd_3", qb[3], 32'h10007);
        end
        chk("t2_matches", a_stat_matches, 32'd4);
        chk("t2_nd_matches", b_stat_matches, 32'd6);
        chk("t2_lane_hits", a_lane_hits, 32'h0F);

        // 3: empty packet terminator
        push('0, 1'b0);
        push('0, 1'b1);
        collect(8);
        chk("t3_cnt", qa.size(), 32'd1);
        if (qa.size() == 1) chk("t3_term", qa[0], 32'h10000);
        chk("t3_matches", a_stat_matches, 32'd4);

        // 4: backpressure, FIFO full, drop, ordered drain
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            s_rules = pk(16'(16'h10 + i), 16'(16'h20 + i), 0, 0, 0, 0, 0, 0);
            s_last  = 1'b1;
            s_valid = 1'b1;
            chk($sformatf("t4_s_ready_%0d", i), a_s_ready, (i <= 5) ? 32'h1 : 32'h0);
            step();
        end
        s_valid = 1'b0;
        s_rules = '0;
        s_last  = 1'b0;
        chk("t4_drops", a_stat_drops, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4_hold_%0d", i), {a_m_valid, a_m_last, a_m_rule_id}, 32'h20011);
            step();
        end
        m_ready = 1'b1;
        collect(14);
        chk("t4_drain_cnt", qa.size(), 32'd10);
        if (qa.size() == 10) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("t4_a_%0d", k), qa[2*k], 32'h10 + k + 1);
                chk($sformatf("t4_b_%0d", k), qa[2*k+1], 32'h10000 | (32'h20 + k + 1));
            end
        end
        chk("t4_matches", a_stat_matches, 32'd14);
        chk("t4_c4_drops", c_stat_drops, 32'd1);

        // 5: clear mid-emission
        push(pk(16'h101, 16'h102, 16'h103, 16'h104, 16'h105, 16'h106, 16'h107, 16'h108), 1'b1);
        step();
        step();
        chk("t5_first", {a_m_valid, a_m_last, a_m_rule_id}, 32'h20101);
        step();
        chk("t5_second", {a_m_valid, a_m_last, a_m_rule_id}, 32'h20102);
        m_ready = 1'b0;
        clear   = 1'b1;
        s_rules = pk(16'h55, 0, 0, 0, 0, 0, 0, 0);
        s_last  = 1'b1;
        s_valid = 1'b1;
        step();
        clear   = 1'b0;
        s_valid = 1'b0;
        s_rules = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        chk("t5_cleared", {a_m_valid, a_m_last, a_m_rule_id}, 32'h0);
        chk("t5_lane_hits", a_lane_hits, 32'h0);
        chk("t5_matches", a_stat_matches, 32'd15);
        chk("t5_drops", a_stat_drops, 32'd1);
        collect(12);
        chk("t5_no_stale", qa.size(), 32'd0);

        // 6a: 4-bit counter saturation
        push(pk(16'h31, 16'h32, 16'h33, 0, 0, 0, 0, 0), 1'b1);
        collect(8);
        chk("t6_cnt", qa.size(), 32'd3);
        chk("t6_c4_sat", c_stat_matches, 32'hF);
        chk("t6_matches", a_stat_matches, 32'd18);
        chk("t6_lane_hits", a_lane_hits, 32'h07);

        // 6b: async reset mid-packet
        push(pk(16'h41, 16'h42, 16'h43, 16'h44, 16'h45, 16'h46, 16'h47, 16'h48), 1'b1);
        step();
        step();
        chk("t6_pre_rst", {a_m_valid, a_m_last, a_m_rule_id}, 32'h20041);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out", {a_m_valid, a_m_last, a_m_rule_id}, 32'h0);
        chk("t6_rst_stats", a_stat_matches | a_stat_drops | 32'(a_lane_hits), 32'h0);
        chk("t6_rst_c4", {c_stat_matches, c_stat_drops}, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        collect(12);
        chk("t6_post_rst", qa.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
